// File: rtl/pwm_capture.sv
// PWM input capture: synchronizes an external PWM signal and measures its high time and period in clock cycles.
// A programmable timeout reports a stuck input level instead of a measurement.
module pwm_capture #(
    parameter int Resolution = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  pwm_i,
    input  logic [Resolution-1:0] timeout_i,
    output logic [Resolution-1:0] high_time_o,
    output logic [Resolution-1:0] period_o,
    output logic                  static_o,
    output logic                  level_o,
    output logic                  valid_o
);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    localparam logic [Resolution-1:0] CntOne = Resolution'(1);

    state_t                state_q;
    logic                  s1_q;
    logic                  s2_q;
    logic                  s3_q;
    logic [Resolution-1:0] cnt_q;
    logic [Resolution-1:0] shadowHigh_q;
    logic [Resolution-1:0] highTime_q;
    logic [Resolution-1:0] period_q;
    logic                  static_q;
    logic                  level_q;
    logic                  valid_q;

    logic                  rise_d;
    logic                  fall_d;
    logic                  timeoutHit_d;
    logic [Resolution-1:0] cntInc_d;

    assign rise_d       = s2_q & ~s3_q;
    assign fall_d       = ~s2_q & s3_q;
    assign timeoutHit_d = (timeout_i != '0) && (cnt_q == timeout_i);
    // The counter saturates rather than wrapping, so a live timeout lowered below it can never match.
    assign cntInc_d     = (cnt_q == '1) ? cnt_q : cnt_q + CntOne;

    // Synchronizer, measurement FSM and registered result outputs; edges always take priority over timeout.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            cnt_q        <= '0;
            shadowHigh_q <= '0;
            highTime_q   <= '0;
            period_q     <= '0;
            static_q     <= 1'b0;
            level_q      <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            s1_q    <= pwm_i;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            valid_q <= 1'b0;
            if (!en_i) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rise_d) begin
                            state_q <= HIGH;
                            cnt_q   <= CntOne;
                        end else begin
                            cnt_q   <= '0;
                        end
                    end
                    HIGH: begin
                        if (fall_d) begin
                            state_q      <= LOW;
                            shadowHigh_q <= cnt_q;
                            cnt_q        <= cntInc_d;
                        end else if (timeoutHit_d) begin
                            state_q    <= IDLE;
                            cnt_q      <= '0;
                            highTime_q <= '0;
                            period_q   <= '0;
                            static_q   <= 1'b1;
                            level_q    <= s2_q;
                            valid_q    <= 1'b1;
                        end else begin
                            cnt_q      <= cntInc_d;
                        end
                    end
                    LOW: begin
                        if (rise_d) begin
                            state_q    <= HIGH;
                            cnt_q      <= CntOne;
                            highTime_q <= shadowHigh_q;
                            period_q   <= cnt_q;
                            static_q   <= 1'b0;
                            valid_q    <= 1'b1;
                        end else if (timeoutHit_d) begin
                            state_q    <= IDLE;
                            cnt_q      <= '0;
                            highTime_q <= '0;
                            period_q   <= '0;
                            static_q   <= 1'b1;
                            level_q    <= s2_q;
                            valid_q    <= 1'b1;
                        end else begin
                            cnt_q      <= cntInc_d;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign high_time_o = highTime_q;
    assign period_o    = period_q;
    assign static_o    = static_q;
    assign level_o     = level_q;
    assign valid_o     = valid_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: drives PWM patterns on the falling edge and logs every valid_o result
// with its cycle number so each scenario can compare against hand-computed values.
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        pwm;
    logic [31:0] timeout;
    logic [31:0] highTime;
    logic [31:0] period;
    logic        staticOut;
    logic        level;
    logic        valid;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] resHigh[$];
    logic [31:0] resPeriod[$];
    logic        resStatic[$];
    logic        resLevel[$];
    int          resCycle[$];

    pwm_capture #(.Resolution(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .pwm_i      (pwm),
        .timeout_i  (timeout),
        .high_time_o(highTime),
        .period_o   (period),
        .static_o   (staticOut),
        .level_o    (level),
        .valid_o    (valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Result logger, sampled shortly after each rising edge so every valid cycle is recorded exactly once.
    always @(posedge clk) begin
        #2;
        if (valid === 1'b1) begin
            resHigh.push_back(highTime);
            resPeriod.push_back(period);
            resStatic.push_back(staticOut);
            resLevel.push_back(level);
            resCycle.push_back(cyc);
        end
    end

    function automatic logic [31:0] hAt(input int i);
        if (i < resHigh.size()) return resHigh[i];
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] pAt(input int i);
        if (i < resPeriod.size()) return resPeriod[i];
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic sAt(input int i);
        if (i < resStatic.size()) return resStatic[i];
        return 1'bx;
    endfunction

    function automatic logic lAt(input int i);
        if (i < resLevel.size()) return resLevel[i];
        return 1'bx;
    endfunction

    function automatic int cAt(input int i);
        if (i < resCycle.size()) return resCycle[i];
        return -1000;
    endfunction

    task automatic clearLog();
        resHigh.delete();
        resPeriod.delete();
        resStatic.delete();
        resLevel.delete();
        resCycle.delete();
    endtask

    task automatic doReset(input logic [31:0] to);
        @(negedge clk);
        rst     = 1'b1;
        en      = 1'b1;
        pwm     = 1'b0;
        timeout = to;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clearLog();
    endtask

    task automatic pulse(input int hi, input int lo);
        pwm = 1'b1;
        repeat (hi) @(negedge clk);
        pwm = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        en      = 1'b1;
        pwm     = 1'b0;
        timeout = 32'd0;
        repeat (3) @(negedge clk);
        checks++; if (highTime !== 32'd0) begin errors++; $display("[TB] FAIL reset_high: got %0d expected 0", highTime); end
        checks++; if (period !== 32'd0) begin errors++; $display("[TB] FAIL reset_period: got %0d expected 0", period); end
        checks++; if (staticOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_static: got %b expected 0", staticOut); end
        checks++; if (level !== 1'b0) begin errors++; $display("[TB] FAIL reset_level: got %b expected 0", level); end
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
        rst = 1'b0;
    endtask

    task automatic test_periodic();
        doReset(32'd0);
        repeat (4) pulse(3, 7);
        checks++; if (resHigh.size() !== 3) begin errors++; $display("[TB] FAIL periodic_count: got %0d expected 3", resHigh.size()); end
        checks++; if (hAt(2) !== 32'd3) begin errors++; $display("[TB] FAIL periodic_high: got %0d expected 3", hAt(2)); end
        checks++; if (pAt(2) !== 32'd10) begin errors++; $display("[TB] FAIL periodic_period: got %0d expected 10", pAt(2)); end
        checks++; if (sAt(2) !== 1'b0) begin errors++; $display("[TB] FAIL periodic_static: got %b expected 0", sAt(2)); end
        checks++; if (cAt(2) - cAt(1) !== 10) begin errors++; $display("[TB] FAIL periodic_spacing: got %0d expected 10", cAt(2) - cAt(1)); end
        checks++; if (highTime !== 32'd3 || period !== 32'd10) begin errors++; $display("[TB] FAIL periodic_hold: got %0d/%0d expected 3/10", highTime, period); end
    endtask

    task automatic test_duty_change();
        int expHigh[4] = '{3, 3, 8, 8};
        doReset(32'd0);
        pulse(3, 7);
        pulse(3, 7);
        pulse(8, 2);
        pulse(8, 2);
        pulse(1, 5);
        checks++; if (resHigh.size() !== 4) begin errors++; $display("[TB] FAIL duty_count: got %0d expected 4", resHigh.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (hAt(i) !== 32'(expHigh[i]) || pAt(i) !== 32'd10) begin
                errors++;
                $display("[TB] FAIL duty_result%0d: got %0d/%0d expected %0d/10", i, hAt(i), pAt(i), expHigh[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int c0;
        doReset(32'd50);
        c0  = cyc;
        pwm = 1'b1;
        repeat (70) @(negedge clk);
        checks++; if (resHigh.size() !== 1) begin errors++; $display("[TB] FAIL timeout_count: got %0d expected 1", resHigh.size()); end
        checks++; if (cAt(0) !== c0 + 53) begin errors++; $display("[TB] FAIL timeout_cycle: got %0d expected %0d", cAt(0), c0 + 53); end
        checks++; if (hAt(0) !== 32'd0 || pAt(0) !== 32'd0) begin errors++; $display("[TB] FAIL timeout_values: got %0d/%0d expected 0/0", hAt(0), pAt(0)); end
        checks++; if (sAt(0) !== 1'b1) begin errors++; $display("[TB] FAIL timeout_static: got %b expected 1", sAt(0)); end
        checks++; if (lAt(0) !== 1'b1) begin errors++; $display("[TB] FAIL timeout_level: got %b expected 1", lAt(0)); end
        repeat (60) @(negedge clk);
        checks++; if (resHigh.size() !== 1) begin errors++; $display("[TB] FAIL timeout_idle: got %0d results expected 1", resHigh.size()); end
        pwm = 1'b0;
        repeat (5) @(negedge clk);
        pulse(4, 6);
        checks++; if (resHigh.size() !== 1) begin errors++; $display("[TB] FAIL timeout_first_rise: got %0d results expected 1", resHigh.size()); end
        pulse(4, 6);
        checks++; if (resHigh.size() !== 2) begin errors++; $display("[TB] FAIL timeout_recover_count: got %0d expected 2", resHigh.size()); end
        checks++; if (hAt(1) !== 32'd4 || pAt(1) !== 32'd10 || sAt(1) !== 1'b0) begin errors++; $display("[TB] FAIL timeout_recover: got %0d/%0d static %b expected 4/10 static 0", hAt(1), pAt(1), sAt(1)); end
    endtask

    task automatic test_edge_at_timeout();
        doReset(32'd10);
        repeat (3) pulse(3, 7);
        pwm = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (resHigh.size() !== 3) begin errors++; $display("[TB] FAIL tie_count: got %0d expected 3", resHigh.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (hAt(i) !== 32'd3 || pAt(i) !== 32'd10 || sAt(i) !== 1'b0) begin
                errors++;
                $display("[TB] FAIL tie_result%0d: got %0d/%0d static %b expected 3/10 static 0", i, hAt(i), pAt(i), sAt(i));
            end
        end
        checks++; if (sAt(2) !== 1'b1 || lAt(2) !== 1'b0) begin errors++; $display("[TB] FAIL tie_low_timeout: got static %b level %b expected 1/0", sAt(2), lAt(2)); end
        checks++; if (cAt(2) - cAt(1) !== 10) begin errors++; $display("[TB] FAIL tie_low_timeout_cycle: got %0d expected 10", cAt(2) - cAt(1)); end
    endtask

    task automatic test_reset_in_low();
        doReset(32'd0);
        pulse(3, 7);
        pulse(3, 7);
        pulse(3, 3);
        checks++; if (resHigh.size() !== 2) begin errors++; $display("[TB] FAIL rstlow_before: got %0d expected 2", resHigh.size()); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (highTime !== 32'd0 || period !== 32'd0) begin errors++; $display("[TB] FAIL rstlow_values: got %0d/%0d expected 0/0", highTime, period); end
        checks++; if (staticOut !== 1'b0 || valid !== 1'b0) begin errors++; $display("[TB] FAIL rstlow_flags: got static %b valid %b expected 0/0", staticOut, valid); end
        rst = 1'b0;
        clearLog();
        pulse(5, 5);
        checks++; if (resHigh.size() !== 0) begin errors++; $display("[TB] FAIL rstlow_first_rise: got %0d results expected 0", resHigh.size()); end
        pulse(5, 5);
        pulse(1, 3);
        checks++; if (resHigh.size() !== 2) begin errors++; $display("[TB] FAIL rstlow_after_count: got %0d expected 2", resHigh.size()); end
        checks++; if (hAt(0) !== 32'd5 || pAt(0) !== 32'd10) begin errors++; $display("[TB] FAIL rstlow_after: got %0d/%0d expected 5/10", hAt(0), pAt(0)); end
    endtask

    task automatic test_enable();
        doReset(32'd0);
        repeat (3) pulse(3, 7);
        pwm = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (resHigh.size() !== 3) begin errors++; $display("[TB] FAIL enable_before: got %0d expected 3", resHigh.size()); end
        en = 1'b0;
        repeat (5) @(negedge clk);
        pwm = 1'b0;
        repeat (15) @(negedge clk);
        checks++; if (resHigh.size() !== 3) begin errors++; $display("[TB] FAIL enable_no_valid: got %0d results expected 3", resHigh.size()); end
        checks++; if (highTime !== 32'd3 || period !== 32'd10) begin errors++; $display("[TB] FAIL enable_hold: got %0d/%0d expected 3/10", highTime, period); end
        en = 1'b1;
        pulse(4, 6);
        checks++; if (resHigh.size() !== 3) begin errors++; $display("[TB] FAIL enable_first_rise: got %0d results expected 3", resHigh.size()); end
        pulse(4, 6);
        pulse(1, 3);
        checks++; if (resHigh.size() !== 5) begin errors++; $display("[TB] FAIL enable_after_count: got %0d expected 5", resHigh.size()); end
        checks++; if (hAt(3) !== 32'd4 || pAt(3) !== 32'd10) begin errors++; $display("[TB] FAIL enable_after: got %0d/%0d expected 4/10", hAt(3), pAt(3)); end
    endtask

    task automatic test_min_pulse();
        doReset(32'd0);
        repeat (4) pulse(1, 1);
        repeat (4) @(negedge clk);
        checks++; if (resHigh.size() !== 3) begin errors++; $display("[TB] FAIL min_count: got %0d expected 3", resHigh.size()); end
        checks++; if (hAt(2) !== 32'd1 || pAt(2) !== 32'd2) begin errors++; $display("[TB] FAIL min_result: got %0d/%0d expected 1/2", hAt(2), pAt(2)); end
        checks++; if (cAt(2) - cAt(1) !== 2) begin errors++; $display("[TB] FAIL min_spacing: got %0d expected 2", cAt(2) - cAt(1)); end
    endtask

    task automatic test_timeout_live();
        doReset(32'd100);
        pwm = 1'b1;
        repeat (30) @(negedge clk);
        timeout = 32'd10;
        repeat (100) @(negedge clk);
        checks++; if (resHigh.size() !== 0) begin errors++; $display("[TB] FAIL live_timeout_passed: got %0d results expected 0", resHigh.size()); end
        checks++; if (staticOut !== 1'b0) begin errors++; $display("[TB] FAIL live_timeout_static: got %b expected 0", staticOut); end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_duty_change();
        test_timeout();
        test_edge_at_timeout();
        test_reset_in_low();
        test_enable();
        test_min_pulse();
        test_timeout_live();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

PWM input-capture block for the peripheral subsystem: the receive-side counterpart of the PWM generator. Samples an external PWM waveform on a single clock, measures its high time and period in clock cycles, and publishes each completed measurement with a one-cycle valid pulse. A programmable timeout detects a static (0 % / 100 % duty) input.

## Interface

- `Resolution`, 32: width of all counters and measurement outputs.
- `clk_i`  input  1  system clock; all logic on its rising edge.
- `rst_i`  input  1  synchronous, active-high reset.
- `en_i`  input  1  capture enable; 0 forces IDLE, counter 0, outputs hold.
- `pwm_i`  input  1  external PWM signal, asynchronous to `clk_i`.
- `timeout_i`  input  Resolution  static-input timeout in cycles; 0 disables.
- `high_time_o`  output  Resolution  last measured high time (cycles).
- `period_o`  output  Resolution  last measured period (cycles).
- `static_o`  output  1  1 if last result came from timeout; holds the stuck level in `level_o`.
- `level_o`  output  1  synchronized input level at timeout.
- `valid_o`  output  1  one-cycle pulse when any output above is updated.

## Operation

- Input path: 2-flop synchronizer (s1, s2) plus history flop s3; rise = s2 & ~s3, fall = ~s2 & s3. Edges alternate by construction.
- Counter `cnt` (Resolution bits): loaded with 1 on an accepted rising edge; otherwise +1 per cycle in HIGH/LOW, saturating at 2^Resolution-1 (no wrap).
- States:
  - IDLE: cnt = 0. Rise -> HIGH, cnt <= 1. Fall ignored. No outputs.
  - HIGH: fall -> LOW, shadow_high <= cnt. Timeout -> IDLE.
  - LOW: rise -> HIGH, cnt <= 1, high_time_o <= shadow_high, period_o <= cnt, static_o <= 0, valid_o pulse. Timeout -> IDLE.
- Timeout: in HIGH or LOW, when `timeout_i` != 0 and cnt == `timeout_i` with no edge this cycle -> IDLE, high_time_o <= 0, period_o <= 0, static_o <= 1, level_o <= s2, valid_o pulse. The first measurement after any timeout/IDLE entry requires a full rise-fall-rise sequence.
- Edge and timeout in the same cycle: edge wins, timeout ignored.
- `en_i` = 0: state IDLE, cnt 0, synchronizer keeps running, measurement outputs hold, `valid_o` 0. Re-enable restarts at IDLE.
- `timeout_i` changed mid-measurement: compared live; if already below cnt, no timeout fires (equality only) and cnt saturates.

## Timing

- Reset (`rst_i` high at clock edge): state IDLE, cnt 0, s1/s2/s3 0, shadow_high 0, high_time_o 0, period_o 0, static_o 0, level_o 0, valid_o 0. Reset mid-measurement discards everything in flight.
- Edge latency: pwm_i transition stable before edge k is acted on at edge k+2 (s1 at k, s2 at k+1, rise/fall decode acted on at k+2). Latency is identical for both polarities, so measurements are exact in cycles.
- With rise acted at edge R, fall at F, next rise at R': high_time_o = F-R, period_o = R'-R, both visible with valid_o = 1 in the cycle after edge R'.
- valid_o is high for exactly one cycle per result; outputs stable until the next valid_o.
- Minimum measurable pulse: 1 cycle high or low (high_time_o = 1, or period_o - high_time_o = 1).
- Timeout fires at the edge where cnt == timeout_i, i.e. timeout_i cycles after the last accepted rise (HIGH) or cnt reaching it in LOW.

## Test plan

- Periodic input, 3 cycles high / 7 low, timeout 0 -> after second rise, high_time_o = 3, period_o = 10, static_o = 0, valid_o pulse once per 10 cycles thereafter.
- Duty change 3/10 -> 8/10 mid-stream -> one result 3/10, next 8/10; no glitch result.
- pwm_i held 1 after a rise, timeout_i = 50 -> valid_o pulse 50 cycles after rise, high_time_o = 0, period_o = 0, static_o = 1, level_o = 1; then IDLE until fresh edges.
- Rising edge arriving exactly when cnt == timeout_i -> normal measurement reported, static_o = 0, no timeout pulse.
- rst_i asserted in LOW state -> next cycle all outputs 0, state IDLE; first valid only after full rise-fall-rise.
- en_i dropped for 20 cycles mid-HIGH -> no valid_o, outputs hold previous 3/10; after re-enable, first result needs complete new period.
